lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 8: consecutive matching samples required to declare lock.
REQ-002 Parameter LOSS_CNT, default 4: consecutive mismatching samples in LOCKED that cause loss of lock.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data carries a sample this cycle.
REQ-006 in_data  input  10  sample from the upstream 10-bit LFSR.
REQ-007 err_clr  input  1  synchronous clear of err_count.
REQ-008 locked  output  1  high while in LOCKED.
REQ-009 err_pulse  output  1  one-cycle pulse per mismatching sample in LOCKED.
REQ-010 err_count  output  16  saturating count of mismatches in LOCKED.
REQ-011 period_done  output  1  one-cycle pulse every 1023 valid samples while LOCKED.
REQ-012 state  output  2  current FSM state encoding.

Function
REQ-013 Next-value function: shift left by one; bit0 = q[9] XOR q[6] (x^10+x^7+1, period 1023).
REQ-014 Cycles with in_valid low change no state, counter or expected value; pulses stay low.
REQ-015 FSM states: SEED=0, VERIFY=1, LOCKED=2; encoding 3 unused and recovers to SEED.
REQ-016 SEED: valid nonzero sample -> exp <= next(in_data), match_cnt <= 0, go VERIFY; all-zero sample ignored.
REQ-017 VERIFY, valid and in_data == exp: match_cnt++, exp <= next(in_data); on the LOCK_CNT-th consecutive match go LOCKED.
REQ-018 VERIFY mismatch: nonzero data reseeds (exp <= next(in_data), match_cnt <= 0, stay VERIFY); zero data -> SEED.
REQ-019 LOCKED: exp <= next(exp) every valid sample (flywheel; never resynchronised to input data).
REQ-020 LOCKED match: miss_cnt <= 0.
REQ-021 LOCKED mismatch: miss_cnt++, err_count saturating +1 (holds at 16'hFFFF), err_pulse high the following cycle.
REQ-022 LOCKED, LOSS_CNT-th consecutive mismatch: go SEED; err_count retained; that mismatch still counted and pulsed.
REQ-023 All outputs registered; locked rises the cycle after the locking sample and falls the cycle after the losing sample.
REQ-024 Period counter: counts valid samples in LOCKED, 0..1022; on the sample where it wraps from 1022 to 0, period_done pulses next cycle.
REQ-025 Period counter clears to 0 on entry to LOCKED and whenever not in LOCKED.
REQ-026 err_clr clears err_count next cycle; err_clr with a simultaneous mismatch yields 0 (clear wins); err_pulse unaffected.

Reset
REQ-027 rst low asynchronously forces: state SEED, exp 0, match_cnt 0, miss_cnt 0, period counter 0, err_count 0, locked 0, err_pulse 0, period_done 0.
REQ-028 rst low mid-lock discards lock; after release, relocking requires the full SEED/VERIFY sequence.

Structure
REQ-029 Shared package lfsr_pkg holds: LFSR_W=10, tap positions (9,6), state enum, and the next-value function, shared with the upstream generator.
REQ-030 Single module, no sub-modules; counter widths derived from parameters via $clog2.

Verification
REQ-031 Reset, then feed 001,002,004,008,010,020,040,081,102 valid every cycle -> locked high one cycle after ninth sample (LOCK_CNT=8), err_count 0.
REQ-032 Locked, inject one corrupted sample (expected 204, send 205), then resume correct sequence -> single err_pulse, err_count 1, locked stays high.
REQ-033 Locked, send 4 consecutive wrong samples -> 4 err_pulses, err_count 4, locked low after fourth, state SEED.
REQ-034 Locked, feed 1023 consecutive correct samples with in_valid gaps -> exactly one period_done, after the 1023rd valid sample; gaps do not advance count.
REQ-035 In SEED, send 000 five times then 001 -> stays SEED through zeros, enters VERIFY after 001.
REQ-036 Force err_count to 16'hFFFF via mismatches, then mismatch with err_clr high -> count holds at FFFF, then reads 0; async rst mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr_pkg                                                        |
// | Purpose  : Shared definitions for the 10-bit LFSR generator and checker.   |
// |            Polynomial x^10 + x^7 + 1, maximal length (period 1023).        |
// | Contents : LFSR_W, tap positions, checker state enum, next-value function. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package lfsr_pkg;

  localparam int LFSR_W      = 10;
  localparam int TAP_HI      = 9;
  localparam int TAP_LO      = 6;
  localparam int LFSR_PERIOD = (1 << LFSR_W) - 1;

  // Encoding 2'd3 is unused; the checker treats it as a fault and returns to SEED.
  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Shift left by one, feedback from the two taps enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr_checker_if                                                 |
// | Purpose  : Sample stream and status bundle between an LFSR source and the  |
// |            lfsr_checker.                                                   |
// | Ports    : in_valid, in_data[9:0], err_clr   (source -> checker)           |
// |            locked, err_pulse, err_count[15:0], period_done, state[1:0]     |
// |                                               (checker -> observer)        |
// | Modports : master (source/observer side), slave (checker side)             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface lfsr_checker_if;
  import lfsr_pkg::*;

  logic              in_valid;
  logic [LFSR_W-1:0] in_data;
  logic              err_clr;
  logic              locked;
  logic              err_pulse;
  logic [15:0]       err_count;
  logic              period_done;
  logic [1:0]        state;

  modport master (
    output in_valid, in_data, err_clr,
    input  locked, err_pulse, err_count, period_done, state
  );

  modport slave (
    input  in_valid, in_data, err_clr,
    output locked, err_pulse, err_count, period_done, state
  );

endinterface
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr_checker                                                    |
// | Purpose  : Locks onto a 10-bit LFSR sample stream, then flywheels its own  |
// |            expected sequence and counts mismatching samples.               |
// | Params   : LOCK_CNT - consecutive matches needed to lock                   |
// |            LOSS_CNT - consecutive mismatches in LOCKED that drop the lock  |
// | Ports    : clk        - clock, rising edge                                 |
// |            rst        - asynchronous reset, active low                     |
// |            bus.slave  - in_valid/in_data/err_clr in;                       |
// |                         locked/err_pulse/err_count/period_done/state out   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  lfsr_checker_if.slave bus
);

  localparam int c_match_w = $clog2(LOCK_CNT + 1);
  localparam int c_miss_w  = $clog2(LOSS_CNT + 1);
  localparam int c_per_w   = $clog2(LFSR_PERIOD);

  // Counter values at which the current sample is the final one of its run.
  localparam logic [c_match_w-1:0] c_lock_last = c_match_w'(LOCK_CNT - 1);
  localparam logic [c_miss_w-1:0]  c_loss_last = c_miss_w'(LOSS_CNT - 1);
  localparam logic [c_per_w-1:0]   c_per_last  = c_per_w'(LFSR_PERIOD - 1);

  state_t             r_state;
  logic [LFSR_W-1:0]  r_exp;
  logic [c_match_w-1:0] r_match_cnt;
  logic [c_miss_w-1:0]  r_miss_cnt;
  logic [c_per_w-1:0]   r_per_cnt;
  logic [15:0]        r_err_count;
  logic               r_locked;
  logic               r_err_pulse;
  logic               r_period_done;

  state_t             w_state;
  logic [LFSR_W-1:0]  w_exp;
  logic [c_match_w-1:0] w_match_cnt;
  logic [c_miss_w-1:0]  w_miss_cnt;
  logic [c_per_w-1:0]   w_per_cnt;
  logic [15:0]        w_err_count;
  logic               w_err_pulse;
  logic               w_period_done;

  logic [LFSR_W-1:0]  w_next_in;
  logic [LFSR_W-1:0]  w_next_exp;
  logic               w_is_match;
  logic               w_is_zero;

  assign w_next_in  = lfsr_next(bus.in_data);
  assign w_next_exp = lfsr_next(r_exp);
  assign w_is_match = (bus.in_data == r_exp);
  assign w_is_zero  = (bus.in_data == '0);

  always_comb begin
    w_state       = r_state;
    w_exp         = r_exp;
    w_match_cnt   = r_match_cnt;
    w_miss_cnt    = r_miss_cnt;
    w_per_cnt     = r_per_cnt;
    w_err_count   = r_err_count;
    w_err_pulse   = 1'b0;
    w_period_done = 1'b0;

    case (r_state)
      ST_SEED: begin
        // All-zero is the LFSR lock-up value and can never seed a valid sequence.
        if (bus.in_valid && !w_is_zero) begin
          w_exp       = w_next_in;
          w_match_cnt = '0;
          w_state     = ST_VERIFY;
        end
      end

      ST_VERIFY: begin
        if (bus.in_valid) begin
          if (w_is_match) begin
            w_exp = w_next_in;
            if (r_match_cnt == c_lock_last) begin
              w_state     = ST_LOCKED;
              w_match_cnt = '0;
              w_miss_cnt  = '0;
            end else begin
              w_match_cnt = r_match_cnt + c_match_w'(1);
            end
          end else if (!w_is_zero) begin
            // Treat the new sample as a fresh seed rather than falling back to SEED.
            w_exp       = w_next_in;
            w_match_cnt = '0;
          end else begin
            w_match_cnt = '0;
            w_state     = ST_SEED;
          end
        end
      end

      ST_LOCKED: begin
        if (bus.in_valid) begin
          // Flywheel: the expected value never follows the input once locked,
          // so a corrupted sample cannot shift the reference sequence.
          w_exp = w_next_exp;

          if (r_per_cnt == c_per_last) begin
            w_per_cnt     = '0;
            w_period_done = 1'b1;
          end else begin
            w_per_cnt = r_per_cnt + c_per_w'(1);
          end

          if (w_is_match) begin
            w_miss_cnt = '0;
          end else begin
            w_err_pulse = 1'b1;
            if (r_err_count != 16'hFFFF) begin
              w_err_count = r_err_count + 16'd1;
            end
            if (r_miss_cnt == c_loss_last) begin
              w_miss_cnt = '0;
              w_state    = ST_SEED;
            end else begin
              w_miss_cnt = r_miss_cnt + c_miss_w'(1);
            end
          end
        end
      end

      default: begin
        w_state = ST_SEED;
      end
    endcase

    // The period count is only meaningful while locked; it restarts from zero
    // on every entry to LOCKED.
    if (w_state != ST_LOCKED) begin
      w_per_cnt = '0;
    end

    // Clear takes priority over a same-cycle increment.
    if (bus.err_clr) begin
      w_err_count = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_SEED;
      r_exp         <= '0;
      r_match_cnt   <= '0;
      r_miss_cnt    <= '0;
      r_per_cnt     <= '0;
      r_err_count   <= '0;
      r_locked      <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_exp         <= w_exp;
      r_match_cnt   <= w_match_cnt;
      r_miss_cnt    <= w_miss_cnt;
      r_per_cnt     <= w_per_cnt;
      r_err_count   <= w_err_count;
      r_locked      <= (w_state == ST_LOCKED);
      r_err_pulse   <= w_err_pulse;
      r_period_done <= w_period_done;
    end
  end

  assign bus.locked      = r_locked;
  assign bus.err_pulse   = r_err_pulse;
  assign bus.err_count   = r_err_count;
  assign bus.period_done = r_period_done;
  assign bus.state       = r_state;

endmodule
`default_nettype wire
